bus_slave_mem: RTL and testbench

- Responder (slave) end of the shared parallel bus: RB/WB strobes, ACK, PARITY and 8-bit address are active-low where noted; the data bus is BUS_WIDTH bits.
- Owns a DEPTH-entry register file mapped at BASE_ADDR..BASE_ADDR+DEPTH-1.
- On a matching write with good parity it stores the data and acknowledges. On a matching read it drives data and parity, then acknowledges.
- Sits on bus_if through the slave modport, alongside other slaves; it releases all shared nets (high-Z) whenever it is not selected.

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_if.sv | 36 +++
 rtl/bus_slave_regfile.sv | 32 +++
 rtl/bus_slave_mem.sv | 134 +++++++++++++
 tb/tb_bus_slave_mem.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the parallel bus: responder FSM states, ACK
// drive levels and the even-parity helper used by both bus ends.
package bus_pkg;

   // Widest data word the parity helper accepts; narrower words are
   // zero-extended, which leaves their parity unchanged.
   localparam int PARITY_MAX_W = 64;

   // ACK is active-low and shared, so an idle responder floats it.
   localparam logic ACK_ASSERT  = 1'b0;
   localparam logic ACK_RELEASE = 1'bz;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WACK = 2'd1,
      RACK = 2'd2,
      WERR = 2'd3
   } bus_slave_state_t;

   // Even parity: a valid word carries PARITY equal to the XOR of its bits.
   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/bus_if.sv
// Shared parallel bus. Strobes and address come from the master; data
// and PARITY are bidirectional; ACK is driven by whichever responder is
// selected. Released nets are held high by weak pull-ups so that an idle
// bus reads as deasserted rather than floating.
interface bus_if #(
   parameter int BUS_WIDTH = 8
);
   logic                 wb_n;
   logic                 rb_n;
   logic [7:0]           addr;
   wire  [BUS_WIDTH-1:0] data;
   wire                  parity;
   wire                  ack_n;

   pullup puData   (data);
   pullup puParity (parity);
   pullup puAck    (ack_n);

   modport slave (
      input  wb_n,
      input  rb_n,
      input  addr,
      inout  data,
      inout  parity,
      output ack_n
   );

   modport master (
      output wb_n,
      output rb_n,
      output addr,
      inout  data,
      inout  parity,
      input  ack_n
   );
endinterface

// File: rtl/bus_slave_regfile.sv
// Register file behind the bus responder: synchronous write,
// combinational read, cleared synchronously on reset.
module bus_slave_regfile #(
   parameter int BUS_WIDTH = 8,
   parameter int DEPTH     = 16,
   parameter int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_we,
   input  logic [IDX_W-1:0]     i_wIdx,
   input  logic [BUS_WIDTH-1:0] i_wData,
   input  logic [IDX_W-1:0]     i_rIdx,
   output logic [BUS_WIDTH-1:0] o_rData
);

   logic [BUS_WIDTH-1:0] r_mem [DEPTH];

   // Store on write enable; reset wipes every entry back to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_wIdx] <= i_wData;
      end
   end

   assign o_rData = r_mem[i_rIdx];

endmodule

// File: rtl/bus_slave_mem.sv
// Bus responder owning DEPTH registers at BASE_ADDR. Accepts writes with
// good parity, serves reads with generated parity, and floats every
// shared net whenever it is not in the middle of its own transaction.
module bus_slave_mem
   import bus_pkg::*;
#(
   parameter int         BUS_WIDTH = 8,
   parameter logic [7:0] BASE_ADDR = 8'h00,
   parameter int         DEPTH     = 16
) (
   input  logic       clk,
   input  logic       rst,
   bus_if.slave       bus,
   output logic       parity_err,
   output logic [7:0] err_count,
   output logic       busy
);

   localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0] SEL_LO = {1'b0, BASE_ADDR};
   localparam logic [8:0] SEL_HI = SEL_LO + 9'(DEPTH);

   bus_slave_state_t r_state;
   logic                 r_ackEn;
   logic                 r_dataEn;
   logic [BUS_WIDTH-1:0] r_dataOut;
   logic                 r_parOut;
   logic                 r_parityErr;
   logic [7:0]           r_errCount;

   logic [8:0]           w_addr9;
   logic                 w_sel;
   logic [IDX_W-1:0]     w_idx;
   logic                 w_wrStrobe;
   logic                 w_rdStrobe;
   logic                 w_parOk;
   logic                 w_we;
   logic [BUS_WIDTH-1:0] w_rData;

   // Address decode: BASE_ADDR is aligned to DEPTH, so the register index
   // is simply the low address bits. Nine-bit compare covers a window
   // ending exactly at 256.
   assign w_addr9    = {1'b0, bus.addr};
   assign w_sel      = (w_addr9 >= SEL_LO) && (w_addr9 < SEL_HI);
   assign w_idx      = bus.addr[IDX_W-1:0];
   assign w_wrStrobe = !bus.wb_n && bus.rb_n;
   assign w_rdStrobe = !bus.rb_n && bus.wb_n;
   assign w_parOk    = (bus.parity == even_parity(PARITY_MAX_W'(bus.data)));
   assign w_we       = (r_state == IDLE) && w_wrStrobe && w_sel && w_parOk;

   bus_slave_regfile #(
      .BUS_WIDTH (BUS_WIDTH),
      .DEPTH     (DEPTH),
      .IDX_W     (IDX_W)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_wIdx  (w_idx),
      .i_wData (bus.data),
      .i_rIdx  (w_idx),
      .o_rData (w_rData)
   );

   // Transaction FSM with registered drive enables, read latch and
   // saturating parity-error counter; reset drops any pending access.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ackEn     <= 1'b0;
         r_dataEn    <= 1'b0;
         r_dataOut   <= '0;
         r_parOut    <= 1'b0;
         r_parityErr <= 1'b0;
         r_errCount  <= 8'd0;
      end else begin
         r_parityErr <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_wrStrobe && w_sel) begin
                  if (w_parOk) begin
                     r_ackEn <= 1'b1;
                     r_state <= WACK;
                  end else begin
                     r_parityErr <= 1'b1;
                     if (r_errCount != 8'hFF) begin
                        r_errCount <= r_errCount + 8'd1;
                     end
                     r_state <= WERR;
                  end
               end else if (w_rdStrobe && w_sel) begin
                  r_dataOut <= w_rData;
                  r_parOut  <= even_parity(PARITY_MAX_W'(w_rData));
                  r_dataEn  <= 1'b1;
                  r_ackEn   <= 1'b1;
                  r_state   <= RACK;
               end
            end
            WACK: begin
               if (bus.wb_n) begin
                  r_ackEn <= 1'b0;
                  r_state <= IDLE;
               end
            end
            RACK: begin
               if (bus.rb_n) begin
                  r_ackEn  <= 1'b0;
                  r_dataEn <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            WERR: begin
               if (bus.wb_n) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_ackEn  <= 1'b0;
               r_dataEn <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.ack_n  = r_ackEn  ? ACK_ASSERT : ACK_RELEASE;
   assign bus.data   = r_dataEn ? r_dataOut  : {BUS_WIDTH{1'bz}};
   assign bus.parity = r_dataEn ? r_parOut   : 1'bz;

   assign parity_err = r_parityErr;
   assign err_count  = r_errCount;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed bench for bus_slave_mem at BASE_ADDR 8'h10, DEPTH 16. The
// bench acts as bus master; released nets read high through the bus
// pull-ups, so a floated ACK/data/PARITY shows up as all ones.
module tb_bus_slave_mem;

   logic       clk = 1'b0;
   logic       rst;
   logic       parityErr;
   logic [7:0] errCount;
   logic       busy;
   logic       mDrive;
   logic [7:0] mData;
   logic       mPar;
   int         totalChecks = 0;
   int         badChecks   = 0;

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   bus_if #(.BUS_WIDTH(8)) busIf ();

   assign busIf.data   = mDrive ? mData : 8'bz;
   assign busIf.parity = mDrive ? mPar  : 1'bz;

   bus_slave_mem #(
      .BUS_WIDTH (8),
      .BASE_ADDR (8'h10),
      .DEPTH     (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (busIf),
      .parity_err (parityErr),
      .err_count  (errCount),
      .busy       (busy)
   );

   // Advance one edge and settle just past it before looking at outputs.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic wbN, input logic rbN, input logic [7:0] addr,
                                input logic drive, input logic [7:0] data, input logic par);
      busIf.wb_n = wbN;
      busIf.rb_n = rbN;
      busIf.addr = addr;
      mDrive     = drive;
      mData      = data;
      mPar       = par;
   endtask

   task automatic idleBus();
      applyStimulus(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic checkReleased(input string tag);
      checkOutput({tag, "_ack"},    32'(busIf.ack_n),  32'h1);
      checkOutput({tag, "_data"},   32'(busIf.data),   32'hFF);
      checkOutput({tag, "_parity"}, 32'(busIf.parity), 32'h1);
   endtask

   // Single-cycle read with release, expecting the given stored word.
   task automatic readExpect(input string tag, input logic [7:0] addr, input logic [7:0] expData);
      logic expPar;
      expPar = ^expData;
      applyStimulus(1'b1, 1'b0, addr, 1'b0, 8'h00, 1'b0);
      tick();
      checkOutput({tag, "_ack"},    32'(busIf.ack_n),  32'h0);
      checkOutput({tag, "_data"},   32'(busIf.data),   32'(expData));
      checkOutput({tag, "_parity"}, 32'(busIf.parity), 32'(expPar));
      checkOutput({tag, "_busy"},   32'(busy),         32'h1);
      idleBus();
      tick();
      checkReleased({tag, "_rel"});
      checkOutput({tag, "_relbusy"}, 32'(busy), 32'h0);
   endtask

   task automatic writeGood(input logic [7:0] addr, input logic [7:0] data);
      applyStimulus(1'b0, 1'b1, addr, 1'b1, data, ^data);
      tick();
      idleBus();
      tick();
   endtask

   task automatic writeBadQuick();
      applyStimulus(1'b0, 1'b1, 8'h12, 1'b1, 8'h07, 1'b0);
      tick();
      idleBus();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      idleBus();
      tick();
      tick();
      rst = 1'b0;
      repeat (5) tick();

      // Reset state
      checkReleased("reset");
      checkOutput("reset_busy",   32'(busy),      32'h0);
      checkOutput("reset_errcnt", 32'(errCount),  32'h0);
      checkOutput("reset_perr",   32'(parityErr), 32'h0);

      // Good write to 0x13, strobe held two cycles
      applyStimulus(1'b0, 1'b1, 8'h13, 1'b1, 8'hA5, 1'b0);
      tick();
      checkOutput("wr13_ack",   32'(busIf.ack_n), 32'h0);
      checkOutput("wr13_busy",  32'(busy),        32'h1);
      checkOutput("wr13_perr",  32'(parityErr),   32'h0);
      tick();
      checkOutput("wr13_hold",  32'(busIf.ack_n), 32'h0);
      idleBus();
      tick();
      checkOutput("wr13_rel",   32'(busIf.ack_n), 32'h1);
      checkOutput("wr13_rbusy", 32'(busy),        32'h0);

      // Read 0x13, held while the address wanders: data stays frozen
      applyStimulus(1'b1, 1'b0, 8'h13, 1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("rd13_ack",    32'(busIf.ack_n),  32'h0);
      checkOutput("rd13_data",   32'(busIf.data),   32'hA5);
      checkOutput("rd13_parity", 32'(busIf.parity), 32'h0);
      applyStimulus(1'b1, 1'b0, 8'h12, 1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("rd13_frozen", 32'(busIf.data),   32'hA5);
      checkOutput("rd13_hold",   32'(busIf.ack_n),  32'h0);
      idleBus();
      tick();
      checkReleased("rd13_rel");

      // Bad-parity write to 0x12
      applyStimulus(1'b0, 1'b1, 8'h12, 1'b1, 8'h07, 1'b0);
      tick();
      checkOutput("bad_perr",   32'(parityErr),   32'h1);
      checkOutput("bad_errcnt", 32'(errCount),    32'h1);
      checkOutput("bad_ack",    32'(busIf.ack_n), 32'h1);
      checkOutput("bad_busy",   32'(busy),        32'h1);
      tick();
      checkOutput("bad_pulse",  32'(parityErr),   32'h0);
      checkOutput("bad_werr",   32'(busy),        32'h1);
      checkOutput("bad_noack",  32'(busIf.ack_n), 32'h1);
      checkOutput("bad_norpt",  32'(errCount),    32'h1);
      idleBus();
      tick();
      checkOutput("bad_idle",   32'(busy),        32'h0);
      readExpect("rd12", 8'h12, 8'h00);

      // Out-of-range read held six cycles
      applyStimulus(1'b1, 1'b0, 8'h20, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         checkReleased("oor");
         checkOutput("oor_busy", 32'(busy), 32'h0);
      end
      idleBus();
      tick();

      // Both strobes low together: ignored
      applyStimulus(1'b0, 1'b0, 8'h10, 1'b1, 8'h3C, 1'b0);
      tick();
      checkOutput("both_ack",  32'(busIf.ack_n), 32'h1);
      checkOutput("both_busy", 32'(busy),        32'h0);
      tick();
      checkOutput("both_ack2", 32'(busIf.ack_n), 32'h1);
      idleBus();
      tick();
      readExpect("rd10", 8'h10, 8'h00);

      // Reset in the middle of a read
      writeGood(8'h15, 8'h5A);
      applyStimulus(1'b1, 1'b0, 8'h15, 1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("rst_rdata", 32'(busIf.data),  32'h5A);
      checkOutput("rst_rack",  32'(busIf.ack_n), 32'h0);
      rst = 1'b1;
      tick();
      checkReleased("rst_mid");
      checkOutput("rst_busy",   32'(busy),     32'h0);
      checkOutput("rst_errcnt", 32'(errCount), 32'h0);
      rst = 1'b0;
      idleBus();
      tick();
      readExpect("rd15", 8'h15, 8'h00);
      readExpect("rd13c", 8'h13, 8'h00);

      // Saturation of the parity-error counter
      for (int i = 0; i < 256; i++) begin
         writeBadQuick();
         if (i == 0)   checkOutput("sat_first", 32'(errCount), 32'd1);
         if (i == 254) checkOutput("sat_255",   32'(errCount), 32'd255);
      end
      checkOutput("sat_hold", 32'(errCount), 32'd255);
      checkOutput("sat_idle", 32'(busy),     32'h0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
